// File: rtl/inst_fetch_pipe_pkg.sv
// Shared definitions for the instruction fetch pipeline: default field
// widths, instruction field offsets and the fetch FSM state type.
package inst_fetch_pipe_pkg;

  localparam int OP_W  = 2;
  localparam int REG_W = 5;
  localparam int IW    = OP_W + 3 * REG_W;

  // Field offsets for the default widths: op | waddr | raddr1 | raddr2 (LSBs)
  localparam int RADDR2_LSB = 0;
  localparam int RADDR1_LSB = REG_W;
  localparam int WADDR_LSB  = 2 * REG_W;
  localparam int OP_LSB     = 3 * REG_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // LSB position of a field, counted from raddr2 upward, for any register width
  function automatic int field_lsb(input int field_idx, input int reg_w);
    return field_idx * reg_w;
  endfunction

endpackage

// File: rtl/inst_fetch_pipe_mem.sv
// Instruction storage: synchronous write, asynchronous read. Because the
// read is combinational from the current contents, a read of the address
// being written in the same cycle sees the old word.
module inst_mem #(
  parameter int DEPTH = 32,
  parameter int IW    = 17,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data
);

  logic [IW-1:0] mem [DEPTH];

  // Program write port; contents are never cleared
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_fetch_pipe.sv
// Instruction fetch pipeline: a program counter walks the instruction
// memory while the FSM is in RUN, presenting one decoded instruction at a
// time through a valid/ready output register. Redirects flush and reload pc.
module inst_fetch_pipe #(
  parameter int DEPTH  = 32,
  parameter int OP_W   = inst_fetch_pipe_pkg::OP_W,
  parameter int REG_W  = inst_fetch_pipe_pkg::REG_W,
  localparam int A_LEN = $clog2(DEPTH),
  localparam int IW    = OP_W + 3 * REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             redirect,
  input  logic [A_LEN-1:0] redirect_pc,
  input  logic             prog_we,
  input  logic [A_LEN-1:0] prog_addr,
  input  logic [IW-1:0]    prog_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OP_W-1:0]  op,
  output logic [REG_W-1:0] waddr,
  output logic [REG_W-1:0] raddr1,
  output logic [REG_W-1:0] raddr2,
  output logic [A_LEN-1:0] out_pc,
  output logic             running
);

  import inst_fetch_pipe_pkg::*;

  localparam int R2_LSB = field_lsb(0, REG_W);
  localparam int R1_LSB = field_lsb(1, REG_W);
  localparam int WA_LSB = field_lsb(2, REG_W);

  state_t           state_q;
  state_t           state_n;
  logic [A_LEN-1:0] pc_q;
  logic             valid_q;
  logic [IW-1:0]    word_q;
  logic [A_LEN-1:0] out_pc_q;
  logic [IW-1:0]    mem_word;
  logic             fetch;
  logic             mem_we;

  // A write arriving together with reset is dropped
  assign mem_we = prog_we & ~rst;

  inst_mem #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (pc_q),
    .rd_data (mem_word)
  );

  // Next-state logic and fetch decision; stop wins over start, and a stop
  // cycle does not fetch so pc holds where it was stopped. Redirect blocks fetch.
  always_comb begin
    state_n = state_q;
    fetch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end
        fetch = !stop && !redirect && (!valid_q || out_ready);
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // pc and output register: redirect flushes, fetch loads, accept drains
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      valid_q  <= 1'b0;
      word_q   <= '0;
      out_pc_q <= '0;
    end else if (redirect) begin
      pc_q    <= redirect_pc;
      valid_q <= 1'b0;
    end else if (fetch) begin
      word_q   <= mem_word;
      out_pc_q <= pc_q;
      valid_q  <= 1'b1;
      pc_q     <= pc_q + A_LEN'(1);
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign op        = word_q[IW-1 -: OP_W];
  assign waddr     = word_q[WA_LSB +: REG_W];
  assign raddr1    = word_q[R1_LSB +: REG_W];
  assign raddr2    = word_q[R2_LSB +: REG_W];
  assign out_pc    = out_pc_q;
  assign running   = (state_q == RUN);

endmodule

// File: tb/tb_inst_fetch_pipe.sv
// Self-checking bench for inst_fetch_pipe against a cycle-level behavioural
// model built from plain integers and an array image of the program memory.
module tb_inst_fetch_pipe;

  localparam int DEPTH = 32;
  localparam int IW    = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          redirect = 1'b0;
  logic [4:0]    redirect_pc = '0;
  logic          prog_we = 1'b0;
  logic [4:0]    prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [1:0]    op;
  logic [4:0]    waddr;
  logic [4:0]    raddr1;
  logic [4:0]    raddr2;
  logic [4:0]    out_pc;
  logic          running;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [IW-1:0] m_mem [DEPTH];
  int            m_pc;
  bit            m_run;
  bit            m_valid;
  logic [IW-1:0] m_word;
  int            m_opc;

  logic [IW-1:0] defaults [4] = '{17'h00001, 17'h08421, 17'h10C63, 17'h18000};

  inst_fetch_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .op          (op),
    .waddr       (waddr),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .out_pc      (out_pc),
    .running     (running)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dut_vec();
    return {out_valid, op, waddr, raddr1, raddr2, out_pc, running};
  endfunction

  function automatic logic [23:0] model_vec();
    logic [4:0] p;
    p = m_opc[4:0];
    return {m_valid, m_word, p, m_run};
  endfunction

  // One clock: DUT and model both advance on the rising edge, then settle
  task automatic step();
    bit do_fetch;
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_run = 0; m_valid = 0; m_word = '0; m_opc = 0;
    end else begin
      do_fetch = m_run && !stop && !redirect && (!m_valid || out_ready);
      if (redirect) begin
        m_pc = int'(redirect_pc);
        m_valid = 0;
      end else if (do_fetch) begin
        m_word = m_mem[m_pc];
        m_opc = m_pc;
        m_valid = 1;
        m_pc = (m_pc + 1) % DEPTH;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (stop) m_run = 0;
      else if (start) m_run = 1;
      if (prog_we) m_mem[int'(prog_addr)] = prog_data;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (dut_vec() !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", dut_vec(), 24'h0);
    end
  endtask

  task automatic test_program();
    for (int a = 0; a < DEPTH; a++) begin
      prog_we = 1'b1;
      prog_addr = 5'(a);
      prog_data = (a < 4) ? defaults[a] : IW'($urandom_range(0, 131071));
      step();
    end
    prog_we = 1'b0;
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL program_idle: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_sequential();
    logic [4:0] exp_f [4][3] = '{'{5'd0, 5'd0, 5'd1}, '{5'd1, 5'd1, 5'd1},
                                 '{5'd3, 5'd3, 5'd3}, '{5'd0, 5'd0, 5'd0}};
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 5'(i) || op !== 2'(i) ||
          waddr !== exp_f[i][0] || raddr1 !== exp_f[i][1] || raddr2 !== exp_f[i][2]) begin
        errors++;
        $display("[TB] FAIL seq_fetch %0d: got v=%b pc=%0d op=%0d w=%0d r1=%0d r2=%0d expected pc=%0d op=%0d w=%0d r1=%0d r2=%0d",
                 i, out_valid, out_pc, op, waddr, raddr1, raddr2, i, i,
                 exp_f[i][0], exp_f[i][1], exp_f[i][2]);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL seq_model %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] held;
    int          next_pc;
    held = model_vec();
    next_pc = (m_opc + 1) % DEPTH;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec() !== held) begin
        errors++;
        $display("[TB] FAIL stall_hold %0d: got %h expected %h", i, dut_vec(), held);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || int'(out_pc) != next_pc || dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL stall_release: got pc=%0d vec=%h expected pc=%0d vec=%h",
               out_pc, dut_vec(), next_pc, model_vec());
    end
  endtask

  task automatic test_redirect();
    int exp_pc [3] = '{-1, 20, 21};
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 5'd5;
    step();
    redirect = 1'b0;
    step();
    checks++;
    if (out_pc !== 5'd5 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL redirect_to5: got pc=%0d v=%b expected pc=5 v=1", out_pc, out_valid);
    end
    redirect = 1'b1;
    redirect_pc = 5'd20;
    for (int i = 0; i < 3; i++) begin
      step();
      redirect = 1'b0;
      checks++;
      if ((i == 0 && out_valid !== 1'b0) ||
          (i > 0 && (out_valid !== 1'b1 || int'(out_pc) != exp_pc[i])) ||
          dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL redirect_seq %0d: got v=%b pc=%0d expected pc=%0d vec=%h",
                 i, out_valid, out_pc, exp_pc[i], model_vec());
      end
    end
  endtask

  task automatic test_wrap();
    int exp_pc [4] = '{30, 31, 0, 1};
    redirect = 1'b1;
    redirect_pc = 5'd30;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || int'(out_pc) != exp_pc[i] || dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL wrap %0d: got v=%b pc=%0d expected pc=%0d", i, out_valid, out_pc, exp_pc[i]);
      end
    end
  endtask

  task automatic test_rw_collision();
    logic [IW-1:0] old_w;
    logic [IW-1:0] new_w;
    old_w = m_mem[7];
    new_w = ~old_w;
    redirect = 1'b1;
    redirect_pc = 5'd7;
    step();
    redirect = 1'b0;
    prog_we = 1'b1;
    prog_addr = 5'd7;
    prog_data = new_w;
    step();
    prog_we = 1'b0;
    checks++;
    if (out_pc !== 5'd7 || {op, waddr, raddr1, raddr2} !== old_w) begin
      errors++;
      $display("[TB] FAIL rw_old: got pc=%0d word=%h expected pc=7 word=%h",
               out_pc, {op, waddr, raddr1, raddr2}, old_w);
    end
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    step();
    checks++;
    if (out_pc !== 5'd7 || {op, waddr, raddr1, raddr2} !== new_w) begin
      errors++;
      $display("[TB] FAIL rw_new: got pc=%0d word=%h expected pc=7 word=%h",
               out_pc, {op, waddr, raddr1, raddr2}, new_w);
    end
  endtask

  task automatic test_stop();
    int held_pc;
    out_ready = 1'b0;
    step();
    held_pc = m_pc;
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (running !== 1'b0 || out_valid !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL stop_pending: got run=%b v=%b vec=%h expected run=0 v=1 vec=%h",
               running, out_valid, dut_vec(), model_vec());
    end
    out_ready = 1'b1;
    step();
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL stop_drain: got v=%b vec=%h expected v=0 vec=%h", out_valid, dut_vec(), model_vec());
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (int'(out_pc) != held_pc || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stop_resume: got pc=%0d v=%b expected pc=%0d v=1", out_pc, out_valid, held_pc);
    end
  endtask

  task automatic test_reset_midrun();
    logic [23:0] exp_first;
    out_ready = 1'b1;
    rst = 1'b1;
    prog_we = 1'b1;
    prog_addr = 5'd0;
    prog_data = ~defaults[0];
    step();
    rst = 1'b0;
    prog_we = 1'b0;
    checks++;
    if (dut_vec() !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_midrun: got %h expected %h", dut_vec(), 24'h0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    exp_first = {1'b1, defaults[0], 5'd0, 1'b1};
    checks++;
    if (dut_vec() !== exp_first) begin
      errors++;
      $display("[TB] FAIL reset_resume: got %h expected %h", dut_vec(), exp_first);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = 5'($urandom_range(0, 31));
      out_ready   = ($urandom_range(0, 3) != 0);
      prog_we     = ($urandom_range(0, 3) == 0);
      prog_addr   = 5'($urandom_range(0, 31));
      prog_data   = IW'($urandom_range(0, 131071));
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; redirect = 1'b0; prog_we = 1'b0;
  endtask

  initial begin
    m_pc = 0; m_run = 0; m_valid = 0; m_word = '0; m_opc = 0;
    test_reset();
    test_program();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_rw_collision();
    test_stop();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
